// File: rtl/xif_result_fifo_if.sv
// Handshake bundle between the posit coprocessor writeback, the commit channel and the
// core's CV-X-IF result channel, as seen by the result buffer.
interface xif_result_fifo_if #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [X_ID_WIDTH-1:0] in_id_i;
  logic [XLEN-1:0]       in_data_i;
  logic [4:0]            in_rd_i;
  logic                  in_we_i;
  logic                  in_exc_i;

  logic                  commit_valid_i;
  logic [X_ID_WIDTH-1:0] commit_id_i;
  logic                  commit_kill_i;

  logic                  result_valid_o;
  logic                  result_ready_i;
  logic [X_ID_WIDTH-1:0] result_id_o;
  logic [XLEN-1:0]       result_data_o;
  logic [4:0]            result_rd_o;
  logic                  result_we_o;
  logic                  result_exc_o;

  logic [CNT_W-1:0]      count_o;

  // Buffer side.
  modport slave (
    input  in_valid_i, in_id_i, in_data_i, in_rd_i, in_we_i, in_exc_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  result_ready_i,
    output in_ready_o,
    output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, result_exc_o,
    output count_o
  );

  // Coprocessor / core side.
  modport master (
    output in_valid_i, in_id_i, in_data_i, in_rd_i, in_we_i, in_exc_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output result_ready_i,
    input  in_ready_o,
    input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, result_exc_o,
    input  count_o
  );
endinterface

// File: rtl/xif_result_fifo.sv
// In-order result buffer between the posit coprocessor and the CV-X-IF result channel.
// Killed entries stay in place and are skipped silently when they reach the head.
module xif_result_fifo #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  xif_result_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       data;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
  } payload_t;

  payload_t         mem [DEPTH];
  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] live;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          full;
  logic          head_occ;
  logic          head_live;
  logic          kill;
  logic          push;
  logic          push_killed;
  logic          pop;
  logic          skip;
  logic          advance;
  payload_t      in_payload;
  payload_t      head;

  assign rd_idx    = rd_ptr[AW-1:0];
  assign wr_idx    = wr_ptr[AW-1:0];
  // Same slot index but opposite wrap bit means the writer has lapped the reader.
  assign full      = (rd_ptr[AW] != wr_ptr[AW]) && (rd_idx == wr_idx);
  assign head_occ  = occ[rd_idx];
  assign head_live = live[rd_idx];
  assign head      = mem[rd_idx];

  assign kill        = bus.commit_valid_i && bus.commit_kill_i;
  assign push        = bus.in_valid_i && !full;
  assign push_killed = kill && (bus.in_id_i == bus.commit_id_i);
  assign pop         = bus.result_valid_o && bus.result_ready_i;
  assign skip        = head_occ && !head_live;
  assign advance     = pop || skip;

  assign in_payload = '{id:   bus.in_id_i,
                        data: bus.in_data_i,
                        rd:   bus.in_rd_i,
                        we:   bus.in_we_i,
                        exc:  bus.in_exc_i};

  assign bus.in_ready_o     = !full;
  assign bus.result_valid_o = head_occ && head_live;
  assign bus.result_id_o    = head.id;
  assign bus.result_data_o  = head.data;
  assign bus.result_rd_o    = head.rd;
  assign bus.result_we_o    = head.we;
  assign bus.result_exc_o   = head.exc;
  assign bus.count_o        = wr_ptr - rd_ptr;

  // NOTE: sequential state is only ever assigned with <= so every slot sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      live   <= '0;
      // NOTE: the payload array is reset as well so the head outputs read 0, not X, after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && occ[i] && (mem[i].id == bus.commit_id_i)) live[i] <= 1'b0;
        // Retiring the head overrides a same-cycle kill, so a popped result is still delivered.
        if (advance && (AW'(i) == rd_idx)) begin
          occ[i]  <= 1'b0;
          live[i] <= 1'b0;
        end
        // Push never targets the head being retired: that needs an empty or a full buffer.
        if (push && (AW'(i) == wr_idx)) begin
          occ[i]  <= 1'b1;
          live[i] <= !push_killed;
          mem[i]  <= in_payload;
        end
      end
      if (advance) rd_ptr <= rd_ptr + PW'(1);
      if (push)    wr_ptr <= wr_ptr + PW'(1);
    end
  end
endmodule

// File: tb/tb_xif_result_fifo.sv
// Self-checking bench for xif_result_fifo: directed vector table, hand sequences for
// hold/reset corners, then randomized traffic against a queue-based reference model.
module tb_xif_result_fifo;
  localparam int DEPTH = 4;
  localparam int XW    = 4;
  localparam int XLEN  = 32;

  logic clk   = 1'b0;
  logic rst_ni = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  xif_result_fifo_if #(.DEPTH(DEPTH), .X_ID_WIDTH(XW), .XLEN(XLEN)) bus ();

  xif_result_fifo #(.DEPTH(DEPTH), .X_ID_WIDTH(XW), .XLEN(XLEN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    string     name;
    bit        in_valid;
    bit [3:0]  in_id;
    bit [31:0] in_data;
    bit [4:0]  in_rd;
    bit        ready;
    bit        commit;
    bit        kill;
    bit [3:0]  commit_id;
    bit        exp_valid;
    bit [3:0]  exp_id;
    bit [31:0] exp_data;
    bit [4:0]  exp_rd;
    int        exp_count;
    bit        exp_in_ready;
  } vec_t;

  typedef struct {
    bit [3:0]  id;
    bit [31:0] data;
    bit [4:0]  rd;
    bit        we;
    bit        exc;
    bit        live;
  } ent_t;

  vec_t vecs[$];
  ent_t model_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t v(string name, bit iv, bit [3:0] iid, bit [31:0] idata, bit [4:0] ird,
                             bit rdy, bit cm, bit kl, bit [3:0] cid,
                             bit ev, bit [3:0] eid, bit [31:0] edata, bit [4:0] erd,
                             int ecnt, bit eir);
    vec_t r;
    r.name = name; r.in_valid = iv; r.in_id = iid; r.in_data = idata; r.in_rd = ird;
    r.ready = rdy; r.commit = cm; r.kill = kl; r.commit_id = cid;
    r.exp_valid = ev; r.exp_id = eid; r.exp_data = edata; r.exp_rd = erd;
    r.exp_count = ecnt; r.exp_in_ready = eir;
    return r;
  endfunction

  task automatic drive(input bit iv, input bit [3:0] iid, input bit [31:0] idata,
                       input bit [4:0] ird, input bit iwe, input bit iexc, input bit rdy,
                       input bit cm, input bit kl, input bit [3:0] cid);
    bus.in_valid_i     = iv;
    bus.in_id_i        = iid;
    bus.in_data_i      = idata;
    bus.in_rd_i        = ird;
    bus.in_we_i        = iwe;
    bus.in_exc_i       = iexc;
    bus.result_ready_i = rdy;
    bus.commit_valid_i = cm;
    bus.commit_kill_i  = kl;
    bus.commit_id_i    = cid;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, rdy, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic check_head(input string tag, input bit [3:0] id, input bit [31:0] data,
                            input bit [4:0] rd, input bit we, input bit exc);
    check({tag, "_valid"}, 32'(bus.result_valid_o), 32'd1);
    check({tag, "_id"},    32'(bus.result_id_o),    32'(id));
    check({tag, "_data"},  bus.result_data_o,       data);
    check({tag, "_rd"},    32'(bus.result_rd_o),    32'(rd));
    check({tag, "_we"},    32'(bus.result_we_o),    32'(we));
    check({tag, "_exc"},   32'(bus.result_exc_o),   32'(exc));
  endtask

  initial begin
    // Directed table: outputs are sampled 1 time unit after the edge that consumed the inputs.
    vecs.push_back(v("t1_push",     1,1,32'hAA,5,   1,0,0,0, 1,1,32'hAA,5,  1,1));
    vecs.push_back(v("t1_pop",      0,0,32'h0,0,    1,0,0,0, 0,0,32'h0,0,   0,1));
    vecs.push_back(v("t2_push0",    1,0,32'hD0,8,   0,0,0,0, 1,0,32'hD0,8,  1,1));
    vecs.push_back(v("t2_push1",    1,1,32'hD1,9,   0,0,0,0, 1,0,32'hD0,8,  2,1));
    vecs.push_back(v("t2_push2",    1,2,32'hD2,10,  0,0,0,0, 1,0,32'hD0,8,  3,1));
    vecs.push_back(v("t2_push3",    1,3,32'hD3,11,  0,0,0,0, 1,0,32'hD0,8,  4,0));
    vecs.push_back(v("t2_full_blk", 1,9,32'hD9,1,   0,0,0,0, 1,0,32'hD0,8,  4,0));
    vecs.push_back(v("t2_pop0_blk", 1,9,32'hD9,1,   1,0,0,0, 1,1,32'hD1,9,  3,1));
    vecs.push_back(v("t2_pop1",     0,0,32'h0,0,    1,0,0,0, 1,2,32'hD2,10, 2,1));
    vecs.push_back(v("t2_pop2",     0,0,32'h0,0,    1,0,0,0, 1,3,32'hD3,11, 1,1));
    vecs.push_back(v("t2_pop3",     0,0,32'h0,0,    1,0,0,0, 0,0,32'h0,0,   0,1));
    vecs.push_back(v("t3_push2",    1,2,32'hE2,12,  0,0,0,0, 1,2,32'hE2,12, 1,1));
    vecs.push_back(v("t3_push3",    1,3,32'hE3,13,  0,0,0,0, 1,2,32'hE2,12, 2,1));
    vecs.push_back(v("t3_push4",    1,4,32'hE4,14,  0,0,0,0, 1,2,32'hE2,12, 3,1));
    vecs.push_back(v("t3_commit",   0,0,32'h0,0,    0,1,0,3, 1,2,32'hE2,12, 3,1));
    vecs.push_back(v("t3_kill3",    0,0,32'h0,0,    0,1,1,3, 1,2,32'hE2,12, 3,1));
    vecs.push_back(v("t3_pop2",     0,0,32'h0,0,    1,0,0,0, 0,0,32'h0,0,   2,1));
    vecs.push_back(v("t3_skip3",    0,0,32'h0,0,    1,0,0,0, 1,4,32'hE4,14, 1,1));
    vecs.push_back(v("t3_pop4",     0,0,32'h0,0,    1,0,0,0, 0,0,32'h0,0,   0,1));
    vecs.push_back(v("t4_pushkill", 1,7,32'hF7,7,   1,1,1,7, 0,0,32'h0,0,   1,1));
    vecs.push_back(v("t4_skip",     0,0,32'h0,0,    1,0,0,0, 0,0,32'h0,0,   0,1));

    // Reset state.
    idle(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",    32'(bus.result_valid_o), 32'd0);
    check("rst_count",    32'(bus.count_o),        32'd0);
    check("rst_in_ready", 32'(bus.in_ready_o),     32'd1);
    check("rst_data",     bus.result_data_o,       32'd0);
    check("rst_id",       32'(bus.result_id_o),    32'd0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      drive(vecs[k].in_valid, vecs[k].in_id, vecs[k].in_data, vecs[k].in_rd, 1'b1, 1'b0,
            vecs[k].ready, vecs[k].commit, vecs[k].kill, vecs[k].commit_id);
      @(posedge clk);
      #1;
      check({vecs[k].name, "_valid"},    32'(bus.result_valid_o), 32'(vecs[k].exp_valid));
      check({vecs[k].name, "_count"},    32'(bus.count_o),        32'(vecs[k].exp_count));
      check({vecs[k].name, "_in_ready"}, 32'(bus.in_ready_o),     32'(vecs[k].exp_in_ready));
      if (vecs[k].exp_valid) begin
        check({vecs[k].name, "_id"},   32'(bus.result_id_o),   32'(vecs[k].exp_id));
        check({vecs[k].name, "_data"}, bus.result_data_o,      vecs[k].exp_data);
        check({vecs[k].name, "_rd"},   32'(bus.result_rd_o),   32'(vecs[k].exp_rd));
      end
    end

    // Head held stable under backpressure while a second result queues behind it.
    drive(1'b1, 4'd1, 32'h1234_5678, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    drive(1'b1, 4'd2, 32'h2222_2222, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      idle(1'b0);
      check_head("t5_hold", 4'd1, 32'h1234_5678, 5'd1, 1'b0, 1'b1);
    end
    check("t5_count", 32'(bus.count_o), 32'd2);
    idle(1'b1);
    @(posedge clk);
    #1;
    check_head("t5_second", 4'd2, 32'h2222_2222, 5'd2, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("t5_empty", 32'(bus.result_valid_o), 32'd0);
    check("t5_count0", 32'(bus.count_o), 32'd0);

    // Asynchronous reset with three entries buffered.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'(c + 8), 32'hC0 + 32'(c), 5'(c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      @(posedge clk);
      #1;
    end
    idle(1'b0);
    check("t6_pre_count", 32'(bus.count_o), 32'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_valid",    32'(bus.result_valid_o), 32'd0);
    check("t6_rst_count",    32'(bus.count_o),        32'd0);
    check("t6_rst_in_ready", 32'(bus.in_ready_o),     32'd1);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    idle(1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("t6_post_valid", 32'(bus.result_valid_o), 32'd0);
      check("t6_post_count", 32'(bus.count_o),        32'd0);
    end

    // Randomized traffic against the queue model; checks and drives happen on the falling edge.
    @(negedge clk);
    for (int c = 0; c < 400; c++) begin
      bit        exp_valid;
      bit        iv, rdy, cm, kl, full;
      bit [3:0]  iid, cid;
      bit [31:0] idata;
      bit [4:0]  ird;
      bit        iwe, iexc;
      ent_t      e;

      exp_valid = (model_q.size() > 0) && model_q[0].live;
      check("rnd_valid",    32'(bus.result_valid_o), 32'(exp_valid));
      check("rnd_count",    32'(bus.count_o),        32'(model_q.size()));
      check("rnd_in_ready", 32'(bus.in_ready_o),     32'(model_q.size() < DEPTH));
      if (exp_valid)
        check_head("rnd_head", model_q[0].id, model_q[0].data, model_q[0].rd,
                   model_q[0].we, model_q[0].exc);

      iv    = ($urandom_range(0, 2) != 0);
      iid   = 4'($urandom_range(0, 3));
      idata = $urandom;
      ird   = 5'($urandom);
      iwe   = 1'($urandom);
      iexc  = 1'($urandom);
      rdy   = ($urandom_range(0, 2) == 0);
      cm    = ($urandom_range(0, 3) == 0);
      kl    = 1'($urandom);
      cid   = 4'($urandom_range(0, 3));
      drive(iv, iid, idata, ird, iwe, iexc, rdy, cm, kl, cid);

      // Next state: retire the head (skip or accepted pop), kill survivors, then enqueue.
      full = (model_q.size() == DEPTH);
      if (model_q.size() > 0 && (!model_q[0].live || rdy)) void'(model_q.pop_front());
      if (cm && kl)
        foreach (model_q[j]) if (model_q[j].id == cid) model_q[j].live = 1'b0;
      if (iv && !full) begin
        e.id = iid; e.data = idata; e.rd = ird; e.we = iwe; e.exc = iexc;
        e.live = !(cm && kl && (iid == cid));
        model_q.push_back(e);
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
